cache_mem_responder: RTL

//  Next-level memory responder for the cache model: accepts line fill (read-miss allocate) and

---
 rtl/cache_mem_responder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory end of the cache miss/writeback interface.
// Latency: an accept at edge 0 raises rsp_valid after edge LATENCY+1; a writeback without
//          WB_ACK_EN completes silently at that same edge.
// Backpressure: req_ready = !full (QDEPTH entries plus one in service); RESP holds until rsp_ready.
//
// Ports:
//   clk, reset_n                         clock (rising edge), async active-low reset
//   req_valid/req_ready/req_rw/req_address   request channel (rw: 0 = fill, 1 = writeback)
//   rsp_valid/rsp_ready/rsp_rw/rsp_address   response channel (address line-aligned)
//   fill_count, wb_count                 completed fills / writebacks, wrap at 2**32
//
// Optional feature macro: WB_ACK_EN. When defined, writebacks also take the response
// handshake (rsp_rw=1). When undefined, writebacks retire straight from BUSY with no response.

// Generic synchronous FIFO: fall-through read of the head entry.
// Latency: a pushed entry is visible at pop_dat after the push edge.
// Backpressure: full/empty reflect the current (pre-edge) occupancy register.
module cache_mem_responder_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // Pointers are PW bits wide, so they wrap modulo DEPTH (a power of 2) on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

module cache_mem_responder #(
  parameter int ADDRESS_SIZE = 16,
  parameter int LINESIZE     = 16,
  parameter int LATENCY      = 4,
  parameter int QDEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDRESS_SIZE-1:0] req_address,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_rw,
  output logic [ADDRESS_SIZE-1:0] rsp_address,
  output logic [31:0]             fill_count,
  output logic [31:0]             wb_count
);

  localparam int AW = ADDRESS_SIZE;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [AW-1:0] LINE_MASK = AW'(LINESIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          work_rw_q;
  logic [AW-1:0] work_addr_q;
  logic [31:0]   fill_count_q;
  logic [31:0]   wb_count_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [AW:0]   head_dat;
  logic          fill_done;
  logic          wb_done;

  // Ready comes straight from the occupancy register, so a pop on the same
  // edge never lets a request in while the FIFO is full.
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;

  // Line alignment happens on the way in; the FIFO only ever holds aligned addresses.
  cache_mem_responder_fifo #(
    .W     (AW + 1),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat ({req_rw, req_address & ~LINE_MASK}),
    .pop      (pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    fill_done = 1'b0;
    wb_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = CW'(LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef WB_ACK_EN
          state_d = RESP;
`else
          // Writebacks retire here without a response beat.
          if (work_rw_q) begin
            state_d = IDLE;
            wb_done = 1'b1;
          end else begin
            state_d = RESP;
          end
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (work_rw_q) wb_done   = 1'b1;
          else           fill_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      work_rw_q    <= 1'b0;
      work_addr_q  <= '0;
      fill_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        work_rw_q   <= head_dat[AW];
        work_addr_q <= head_dat[AW-1:0];
      end
      if (fill_done) fill_count_q <= fill_count_q + 32'd1;
      if (wb_done)   wb_count_q   <= wb_count_q + 32'd1;
    end
  end

  // The working register only changes on a pop, which cannot happen in RESP,
  // so the response fields stay stable for the whole handshake.
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rw      = work_rw_q;
  assign rsp_address = work_addr_q;
  assign fill_count  = fill_count_q;
  assign wb_count    = wb_count_q;

endmodule
